// File: rtl/tpu_host_pkg.sv
// Shared types and constants for the TPU host driver: FSM state encoding,
// default buffer geometry and the rounding-up division used for word counts.
package tpu_host_pkg;

  localparam int DEF_IDX_W = 16;
  localparam int DEF_AB_W  = 32;
  localparam int DEF_C_W   = 128;
  localparam int DEF_PE    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    DRAIN_C
  } state_t;

  function automatic logic [15:0] ceil_div(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} - 17'd1;
    return 16'(s / {1'b0, b});
  endfunction

endpackage

// File: rtl/c_out_fifo.sv
// Two-entry output FIFO holding C words read back from the C buffer
// until the downstream consumer accepts them.
module c_out_fifo
  import tpu_host_pkg::*;
#(
  parameter int W = DEF_C_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/tpu_host_driver.sv
// Host-side job sequencer for the TPU core: streams A/B into the global
// buffers, launches the core, waits for completion and drains C downstream.
module tpu_host_driver
  import tpu_host_pkg::*;
#(
  parameter int IDX_W        = DEF_IDX_W,
  parameter int AB_W         = DEF_AB_W,
  parameter int C_W          = DEF_C_W,
  parameter int PE           = DEF_PE,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cfg_K,
  input  logic [7:0]       cfg_M,
  input  logic [7:0]       cfg_N,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [AB_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [C_W-1:0]   m_data,
  output logic             done,
  output logic             err,
  output logic             host_owns,
  output logic             tpu_in_valid,
  output logic [7:0]       tpu_K,
  output logic [7:0]       tpu_M,
  output logic [7:0]       tpu_N,
  input  logic             tpu_busy,
  output logic             A_wr_en,
  output logic [IDX_W-1:0] A_index,
  output logic [AB_W-1:0]  A_data_in,
  output logic             B_wr_en,
  output logic [IDX_W-1:0] B_index,
  output logic [AB_W-1:0]  B_data_in,
  output logic             C_wr_en,
  output logic [IDX_W-1:0] C_index,
  output logic [C_W-1:0]   C_data_in,
  input  logic [C_W-1:0]   C_data_out
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t           state, state_n;
  logic [7:0]       k_q, m_q, n_q;
  logic [IDX_W-1:0] na_q, nb_q, nc_q;
  logic [IDX_W-1:0] idx_q, rd_idx_q, out_cnt_q;
  logic [TW-1:0]    tmr_q;
  logic             inflight_q, done_q, err_q;
  logic [1:0]       fifo_count;
  logic [C_W-1:0]   fifo_head;
  logic [15:0]      na_d, nb_d, nc_d;
  logic             dims_ok, accept, last_in, pop, last_out, issue, timeout;

  assign na_d    = 16'(cfg_K) * ceil_div(16'(cfg_M), 16'(PE));
  assign nb_d    = 16'(cfg_K) * ceil_div(16'(cfg_N), 16'(PE));
  assign nc_d    = 16'(cfg_M) * ceil_div(16'(cfg_N), 16'(PE));
  assign dims_ok = (cfg_K != 8'd0) && (cfg_M != 8'd0) && (cfg_N != 8'd0);

  assign accept   = s_valid && s_ready;
  assign last_in  = idx_q == (((state == LOAD_A) ? na_q : nb_q) - IDX_W'(1));
  assign pop      = m_valid && m_ready;
  assign last_out = (state == DRAIN_C) && pop && (out_cnt_q == nc_q - IDX_W'(1));
  assign timeout  = tmr_q == TW'(BUSY_TIMEOUT - 1);
  // Reads in flight are counted against FIFO space so no returning word is ever dropped.
  assign issue    = (state == DRAIN_C) && (rd_idx_q != nc_q) &&
                    (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start && dims_ok) state_n = LOAD_A;
      LOAD_A:    if (accept && last_in) state_n = LOAD_B;
      LOAD_B:    if (accept && last_in) state_n = LAUNCH;
      LAUNCH:    state_n = WAIT_BUSY;
      WAIT_BUSY: if (tpu_busy) state_n = RUN;
                 else if (timeout) state_n = IDLE;
      RUN:       if (!tpu_busy) state_n = DRAIN_C;
      DRAIN_C:   if (last_out) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    s_ready      = 1'b0;
    host_owns    = 1'b1;
    tpu_in_valid = 1'b0;
    A_wr_en      = 1'b0;
    A_index      = '0;
    A_data_in    = '0;
    B_wr_en      = 1'b0;
    B_index      = '0;
    B_data_in    = '0;
    C_index      = '0;
    case (state)
      LOAD_A: begin
        s_ready   = 1'b1;
        A_wr_en   = s_valid;
        A_index   = idx_q;
        A_data_in = s_data;
      end
      LOAD_B: begin
        s_ready   = 1'b1;
        B_wr_en   = s_valid;
        B_index   = idx_q;
        B_data_in = s_data;
      end
      LAUNCH: begin
        host_owns    = 1'b0;
        tpu_in_valid = 1'b1;
      end
      WAIT_BUSY, RUN: host_owns = 1'b0;
      DRAIN_C:        if (issue) C_index = rd_idx_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      na_q       <= '0;
      nb_q       <= '0;
      nc_q       <= '0;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      out_cnt_q  <= '0;
      tmr_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= issue;
      done_q     <= last_out;
      err_q      <= ((state == IDLE) && start && !dims_ok) ||
                    ((state == WAIT_BUSY) && !tpu_busy && timeout);
      case (state)
        IDLE: if (start && dims_ok) begin
          k_q       <= cfg_K;
          m_q       <= cfg_M;
          n_q       <= cfg_N;
          na_q      <= IDX_W'(na_d);
          nb_q      <= IDX_W'(nb_d);
          nc_q      <= IDX_W'(nc_d);
          idx_q     <= '0;
          rd_idx_q  <= '0;
          out_cnt_q <= '0;
        end
        LOAD_A, LOAD_B: if (accept) idx_q <= last_in ? '0 : idx_q + IDX_W'(1);
        LAUNCH:    tmr_q <= '0;
        WAIT_BUSY: begin
          tmr_q <= tmr_q + TW'(1);
          if (!tpu_busy && timeout) begin
            k_q <= '0;
            m_q <= '0;
            n_q <= '0;
          end
        end
        DRAIN_C: begin
          if (issue) rd_idx_q <= rd_idx_q + IDX_W'(1);
          if (pop)   out_cnt_q <= out_cnt_q + IDX_W'(1);
          if (last_out) begin
            k_q <= '0;
            m_q <= '0;
            n_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  c_out_fifo #(.W(C_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (C_data_out),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign m_valid   = fifo_count != 2'd0;
  assign m_data    = m_valid ? fifo_head : '0;
  assign done      = done_q;
  assign err       = err_q;
  assign tpu_K     = k_q;
  assign tpu_M     = m_q;
  assign tpu_N     = n_q;
  assign C_wr_en   = 1'b0;
  assign C_data_in = '0;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Self-checking bench for tpu_host_driver: table of jobs plus random jobs, with a
// queue-based buffer/TPU model and hand sequences for reset aborts.
module tb_tpu_host_driver;
  import tpu_host_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start, s_valid, s_ready, m_valid, m_ready, done, err;
  logic         host_owns, tpu_in_valid, tpu_busy, A_wr_en, B_wr_en, C_wr_en;
  logic [7:0]   cfg_K, cfg_M, cfg_N, tpu_K, tpu_M, tpu_N;
  logic [31:0]  s_data, A_data_in, B_data_in;
  logic [15:0]  A_index, B_index, C_index;
  logic [127:0] m_data, C_data_in, C_data_out;

  always #5 clk = ~clk;

  tpu_host_driver #(.IDX_W(16), .AB_W(32), .C_W(128), .PE(4), .BUSY_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_K(cfg_K), .cfg_M(cfg_M), .cfg_N(cfg_N),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .done(done), .err(err), .host_owns(host_owns), .tpu_in_valid(tpu_in_valid),
    .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N), .tpu_busy(tpu_busy),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
    .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in), .C_data_out(C_data_out)
  );

  typedef struct {
    logic [15:0] idx;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int k, m, n, busy_en, mr_mode, exp_err, e_na, e_nb, e_nc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0]  stream [$];
  logic [31:0]  fed [$];
  wr_t          aw [$];
  wr_t          bw [$];
  logic [127:0] mo [$];
  logic [127:0] c_mem [16384];
  logic [15:0]  cidx_prev;
  int busy_cnt, hold;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    tpu_busy = 1'b0;
    C_data_out = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"},   s_ready, 0);
    check({tag, "_host_owns"}, host_owns, 1);
    check({tag, "_in_valid"},  tpu_in_valid, 0);
    check({tag, "_m_valid"},   m_valid, 0);
    check({tag, "_m_data"},    m_data, 0);
    check({tag, "_done_err"},  {done, err}, 0);
    check({tag, "_tpu_dims"},  {tpu_K, tpu_M, tpu_N}, 0);
    check({tag, "_wr_idx"},    {A_wr_en, B_wr_en, C_index}, 0);
  endtask

  // Pulse rst for one cycle and check outputs in the cycle that follows.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    busy_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    check_reset(tag);
  endtask

  task automatic run_job(input vec_t v, input int abort, input string tag);
    int cyc, inv_cnt, done_cnt, err_cnt, err_cyc, inv_cyc, own_viol, cwr_viol, cidx_max, bad;
    int na, nb, nc, held;
    logic [23:0] lat;
    na = v.k * ((v.m + 3) / 4);
    nb = v.k * ((v.n + 3) / 4);
    nc = v.m * ((v.n + 3) / 4);
    stream.delete(); fed.delete(); aw.delete(); bw.delete(); mo.delete();
    for (int i = 0; i < na + nb; i++) stream.push_back($urandom);
    for (int i = 0; i < nc; i++) c_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0; inv_cnt = 0; done_cnt = 0; err_cnt = 0; err_cyc = -1; inv_cyc = -1;
    own_viol = 0; cwr_viol = 0; cidx_max = 0; held = 0; hold = 0; busy_cnt = 0;
    cidx_prev = '0; lat = '0;
    cfg_K = 8'(v.k); cfg_M = 8'(v.m); cfg_N = 8'(v.n);
    while (cyc < 4000 && done_cnt == 0 && err_cnt == 0) begin
      @(posedge clk); #1;
      if (cyc == 0) start = 1'b1;
      else start = (v.exp_err == 0) && (cyc > 1) && (stream.size() > 0) && ($urandom_range(7) == 0);
      if (stream.size() > 0) begin
        s_valid = $urandom_range(3) != 0;
        s_data  = stream[0];
      end else begin
        s_valid = $urandom_range(1) == 1;
        s_data  = $urandom;
      end
      tpu_busy = busy_cnt > 0;
      if (busy_cnt > 0) busy_cnt--;
      C_data_out = c_mem[cidx_prev];
      case (v.mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = $urandom_range(1) == 1;
        default: m_ready = (hold == 0) && ($urandom_range(1) == 1);
      endcase
      if (hold > 0) hold--;
      #2;
      if (A_wr_en) begin
        aw.push_back('{A_index, A_data_in});
        if (!host_owns) own_viol++;
      end
      if (B_wr_en) begin
        bw.push_back('{B_index, B_data_in});
        if (!host_owns) own_viol++;
      end
      if (s_valid && s_ready) begin
        fed.push_back(s_data);
        if (stream.size() > 0) void'(stream.pop_front());
      end
      if (tpu_in_valid) begin
        inv_cnt++;
        inv_cyc = cyc;
        lat = {tpu_K, tpu_M, tpu_N};
        if (v.busy_en != 0) busy_cnt = 20;
      end
      if (m_valid && m_ready) mo.push_back(m_data);
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (C_wr_en || C_data_in != '0) cwr_viol++;
      if (int'(C_index) > cidx_max) cidx_max = int'(C_index);
      cidx_prev = C_index;
      if (v.mr_mode == 2 && mo.size() == 1 && held == 0) begin
        hold = 10;
        held = 1;
      end
      if ((abort == 1 && bw.size() >= 2) || (abort == 2 && mo.size() >= 2)) begin
        do_reset({tag, "_rst"});
        return;
      end
      cyc++;
    end
    @(posedge clk); #1;
    idle_inputs();
    #2;
    check({tag, "_idle_own"}, {host_owns, s_ready, tpu_in_valid}, 3'b100);
    if (v.exp_err == 1) begin
      check({tag, "_err_cnt"}, err_cnt, 1);
      check({tag, "_err_lat"}, err_cyc, 1);
      check({tag, "_no_writes"}, aw.size() + bw.size(), 0);
      check({tag, "_no_launch"}, inv_cnt + done_cnt, 0);
    end else begin
      check({tag, "_na"}, aw.size(), v.e_na);
      check({tag, "_nb"}, bw.size(), v.e_nb);
      bad = 0;
      for (int i = 0; i < aw.size(); i++)
        if (aw[i].idx != 16'(i) || i >= fed.size() || aw[i].d != fed[i]) bad++;
      for (int i = 0; i < bw.size(); i++)
        if (bw[i].idx != 16'(i) || na + i >= fed.size() || bw[i].d != fed[na + i]) bad++;
      check({tag, "_ab_data"}, bad, 0);
      check({tag, "_in_valid"}, inv_cnt, 1);
      check({tag, "_dims"}, lat, {8'(v.k), 8'(v.m), 8'(v.n)});
      check({tag, "_own_viol"}, own_viol + cwr_viol, 0);
      if (v.exp_err == 2) begin
        check({tag, "_to_err"}, err_cnt, 1);
        check({tag, "_to_lat"}, (err_cyc - inv_cyc >= 1024) && (err_cyc - inv_cyc <= 1026), 1);
        check({tag, "_to_nodone"}, done_cnt + mo.size(), 0);
      end else begin
        check({tag, "_nc"}, mo.size(), v.e_nc);
        bad = 0;
        for (int i = 0; i < mo.size(); i++) if (mo[i] != c_mem[i]) bad++;
        check({tag, "_c_data"}, bad, 0);
        check({tag, "_cidx_max"}, cidx_max, v.e_nc - 1);
        check({tag, "_done_err"}, {done_cnt[1:0], err_cnt[1:0]}, 4'b0100);
      end
    end
  endtask

  vec_t vec [9];

  initial begin
    vec_t rv;
    vec[0] = '{4, 4, 4, 1, 0, 0, 4, 4, 4};
    vec[1] = '{3, 5, 6, 1, 0, 0, 6, 6, 10};
    vec[2] = '{4, 4, 0, 1, 0, 1, 0, 0, 0};
    vec[3] = '{2, 8, 3, 1, 1, 0, 4, 2, 8};
    vec[4] = '{9, 13, 2, 1, 2, 0, 36, 9, 13};
    vec[5] = '{0, 3, 3, 1, 0, 1, 0, 0, 0};
    vec[6] = '{2, 2, 2, 0, 0, 2, 2, 2, 2};
    vec[7] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
    vec[8] = '{255, 4, 4, 1, 1, 0, 255, 255, 4};
    rst = 1'b1;
    cfg_K = '0; cfg_M = '0; cfg_N = '0;
    idle_inputs();
    busy_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_reset("por");

    for (int i = 0; i < 9; i++) run_job(vec[i], 0, $sformatf("vec%0d", i));

    run_job('{5, 6, 7, 1, 0, 0, 10, 10, 12}, 1, "abort_loadb");
    run_job('{3, 5, 6, 1, 2, 0, 6, 6, 10}, 0, "after_loadb");
    run_job('{3, 8, 8, 1, 1, 0, 6, 6, 16}, 2, "abort_drain");
    run_job('{4, 4, 4, 1, 2, 0, 4, 4, 4}, 0, "after_drain");

    for (int j = 0; j < 6; j++) begin
      rv.k = $urandom_range(12, 1);
      rv.m = $urandom_range(12, 1);
      rv.n = $urandom_range(12, 1);
      rv.busy_en = 1;
      rv.mr_mode = $urandom_range(2);
      rv.exp_err = 0;
      rv.e_na = rv.k * ((rv.m + 3) / 4);
      rv.e_nb = rv.k * ((rv.n + 3) / 4);
      rv.e_nc = rv.m * ((rv.n + 3) / 4);
      run_job(rv, 0, $sformatf("rand%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
